mem_port_arbiter: RTL

- Two-requester arbiter that shares one memory port between requester A (instruction fetch) and requester B (load/store).
- Owns the select line of the shared address/data muxes and sequences one transaction at a time.
- Alternates priority on contention and routes the memory acknowledge back to the granted requester.
- Sits between the CPU front-end/LSU and the single-ported memory interface.

---
 rtl/mem_port_arbiter_pkg.sv | 16 +
 rtl/arb_timeout_ctr.sv | 28 ++
 rtl/mem_port_arbiter_mux2.sv | 11 +
 rtl/mem_port_arbiter.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - state encodings, select constants and default widths for mem_port_arbiter
package mem_port_arbiter_pkg;

    localparam int DEF_AW = 16;
    localparam int DEF_DW = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_A = 2'd1,
        GRANT_B = 2'd2
    } arb_state_t;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/arb_timeout_ctr.sv
// rtl/arb_timeout_ctr.sv - grant age counter with terminal compare; built only with ARB_TIMEOUT_EN
`ifdef ARB_TIMEOUT_EN
module arb_timeout_ctr #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic tc
);

    logic [7:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + 8'd1;
        end
    end

    assign tc = (cnt == 8'(TIMEOUT - 1));

endmodule
`endif

// File: rtl/mem_port_arbiter_mux2.sv
// rtl/mem_port_arbiter_mux2.sv - single-bit 2:1 mux cell used for the shared memory port fields
module mem_port_arbiter_mux2 (
    input  logic d0,
    input  logic d1,
    input  logic s,
    output logic y
);

    assign y = s ? d1 : d0;

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-requester single memory port arbiter; ARB_TIMEOUT_EN adds grant timeout abort
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW
`ifdef ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 64
`endif
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          a_req,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    input  logic          a_we,
    output logic          a_ack,
    input  logic          b_req,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    input  logic          b_we,
    output logic          b_ack,
    output logic [DW-1:0] rdata,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_rdata,
    output logic          sel
`ifdef ARB_TIMEOUT_EN
    ,
    output logic          timeout_err
`endif
);

    localparam int BW = AW + DW + 1;

    arb_state_t state, state_nxt;
    logic       sel_nxt;
    logic       last, last_nxt;
    logic       granted;
    logic       abort;
    logic       done;

    assign granted = (state != IDLE);

`ifdef ARB_TIMEOUT_EN
    logic entry;
    logic tc;

    assign entry = (state_nxt != IDLE) && (state_nxt != state);

    arb_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_ctr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (entry),
        .inc   (granted && !mem_ack),
        .tc    (tc)
    );

    // mem_ack in the terminal cycle wins over the abort
    assign abort       = granted && tc && !mem_ack;
    assign timeout_err = abort;
`else
    assign abort = 1'b0;
`endif

    assign done = granted && (mem_ack || abort);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            sel   <= SEL_A;
            last  <= SEL_B;
        end else begin
            state <= state_nxt;
            sel   <= sel_nxt;
            last  <= last_nxt;
        end
    end

    // the grantee's own req in its ack cycle is stale, so only the other side can follow directly
    always_comb begin
        state_nxt = state;
        sel_nxt   = sel;
        last_nxt  = last;
        case (state)
            IDLE: begin
                if (a_req && (!b_req || last == SEL_B)) begin
                    state_nxt = GRANT_A;
                    sel_nxt   = SEL_A;
                    last_nxt  = SEL_A;
                end else if (b_req) begin
                    state_nxt = GRANT_B;
                    sel_nxt   = SEL_B;
                    last_nxt  = SEL_B;
                end
            end
            GRANT_A: begin
                if (done) begin
                    if (b_req) begin
                        state_nxt = GRANT_B;
                        sel_nxt   = SEL_B;
                        last_nxt  = SEL_B;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            GRANT_B: begin
                if (done) begin
                    if (a_req) begin
                        state_nxt = GRANT_A;
                        sel_nxt   = SEL_A;
                        last_nxt  = SEL_A;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    logic [BW-1:0] a_bus;
    logic [BW-1:0] b_bus;
    logic [BW-1:0] mux_bus;

    assign a_bus = {a_addr, a_wdata, a_we};
    assign b_bus = {b_addr, b_wdata, b_we};

    for (genvar i = 0; i < BW; i++) begin : g_mux
        mem_port_arbiter_mux2 u_mux (
            .d0 (a_bus[i]),
            .d1 (b_bus[i]),
            .s  (sel),
            .y  (mux_bus[i])
        );
    end

    assign {mem_addr, mem_wdata, mem_we} = mux_bus & {BW{granted}};
    assign mem_req = granted;
    assign a_ack   = (state == GRANT_A) && done;
    assign b_ack   = (state == GRANT_B) && done;
    assign rdata   = (rst_n && !abort) ? mem_rdata : '0;

endmodule
